cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with trap and halt handling.
// Optional retired-instruction counter enabled by defining CPU_SEQ_INSTRET_EN.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 instr_valid,
    input  logic                 mem_done,
    input  logic                 mem_err,
    input  logic                 halt_req,
    output logic [2:0]           stage,
    output logic                 mem_start,
    output logic                 mem_fetch,
    output logic                 mem_we,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 rf_we,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state_reg, state_next;
    logic            pending_reg, pending_next;
    logic            mem_start_reg;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [1:0]      cause_reg, cause_next;
    logic            waiting, accept, timeout_hit;
    logic            is_load, is_store, is_branch;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // A response only counts once the request pulse has gone out, so stale
    // completions from an abandoned access can never be mistaken for ours.
    assign waiting     = ((state_reg == ST_FETCH) || (state_reg == ST_MEMORY))
                         && !pending_reg && !mem_start_reg;
    assign accept      = waiting && mem_done;
    assign timeout_hit = (MEM_TIMEOUT != 0) && waiting
                         && (to_cnt_reg == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        mem_fetch  = 1'b0;
        mem_we     = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        rf_we      = 1'b0;
        trap       = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_fetch = 1'b1;
                if (accept) begin
                    if (mem_err) begin
                        state_next = ST_TRAP;
                        cause_next = 2'd1;
                    end else begin
                        ir_en      = 1'b1;
                        state_next = ST_DECODE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    cause_next = 2'd2;
                end
            end
            ST_DECODE: begin
                if (!instr_valid) begin
                    state_next = ST_TRAP;
                    cause_next = 2'd0;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_next = (is_load || is_store) ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                mem_we = is_store;
                if (accept) begin
                    if (mem_err) begin
                        state_next = ST_TRAP;
                        cause_next = 2'd1;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    cause_next = 2'd2;
                end
            end
            ST_WRITEBACK: begin
                pc_en      = 1'b1;
                rf_we      = !(is_store || is_branch);
                state_next = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                pc_en      = 1'b1;
                state_next = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (!halt_req) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase

        pending_next = (state_next != state_reg)
                       && ((state_next == ST_FETCH) || (state_next == ST_MEMORY));

        to_cnt_next = to_cnt_reg;
        if (mem_start_reg)
            to_cnt_next = '0;
        else if (waiting)
            to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_FETCH;
            pending_reg   <= 1'b1;
            mem_start_reg <= 1'b0;
            to_cnt_reg    <= '0;
            cause_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            mem_start_reg <= pending_reg;
            to_cnt_reg    <= to_cnt_next;
            cause_reg     <= cause_next;
        end
    end

    assign stage      = state_reg;
    assign mem_start  = mem_start_reg;
    assign trap_cause = cause_reg;

`ifdef CPU_SEQ_INSTRET_EN
    logic [INSTRET_W-1:0] instret_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret_reg <= '0;
        else if (state_reg == ST_WRITEBACK)
            instret_reg <= instret_reg + INSTRET_W'(1);
    end

    assign instret = instret_reg;
`else
    assign instret = '0;
`endif

endmodule
